branch_target_predictor: RTL and testbench



---
 rtl/mips_core_pkg.sv | 27 ++
 rtl/mips_core_ifc.sv | 32 +++
 rtl/btb_entry_update.sv | 47 ++++
 rtl/branch_target_predictor.sv | 114 +++++++++++
 tb/tb_branch_target_predictor.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/mips_core_pkg.sv
// rtl/mips_core_pkg.sv - shared core types: branch outcome, BTB entry, direction counter encodings
package mips_core_pkg;

    localparam int ADDR_WIDTH = 32;

    typedef enum logic {
        NOT_TAKEN = 1'b0,
        TAKEN     = 1'b1
    } BranchOutcome;

    localparam logic [1:0] CTR_SNT   = 2'b00;
    localparam logic [1:0] CTR_WNT   = 2'b01;
    localparam logic [1:0] CTR_WT    = 2'b10;
    localparam logic [1:0] CTR_STT   = 2'b11;
    localparam logic [1:0] CTR_RESET = CTR_WNT;
    localparam logic [1:0] CTR_ALLOC = CTR_WT;

    // Tag is held zero-extended to the full address width so the struct
    // does not depend on the predictor's INDEX_WIDTH parameter.
    typedef struct packed {
        logic                  valid;
        logic [ADDR_WIDTH-1:0] tag;
        logic [ADDR_WIDTH-1:0] target;
        logic [1:0]            ctr;
    } BtbEntry;

endpackage

// File: rtl/mips_core_ifc.sv
// rtl/mips_core_ifc.sv - fetch PC, branch prediction and decode resolution interfaces
interface pc_ifc;
    import mips_core_pkg::*;

    logic [ADDR_WIDTH-1:0] pc;

    modport in  (input pc);
    modport out (output pc);
endinterface

interface branch_prediction_ifc;
    import mips_core_pkg::*;

    logic                  valid;
    logic [ADDR_WIDTH-1:0] target;
    BranchOutcome          prediction;
    logic [ADDR_WIDTH-1:0] recovery_target;

    modport in  (input valid, target, prediction, recovery_target);
    modport out (output valid, target, prediction, recovery_target);
endinterface

interface branch_decode_ifc;
    import mips_core_pkg::*;

    logic                  valid;
    logic [ADDR_WIDTH-1:0] target;
    BranchOutcome          outcome;

    modport in  (input valid, target, outcome);
    modport out (output valid, target, outcome);
endinterface

// File: rtl/btb_entry_update.sv
// rtl/btb_entry_update.sv - next-entry function for one BTB slot given a pending resolution
module btb_entry_update
    import mips_core_pkg::*;
(
    input  logic                  u_valid,
    input  BtbEntry               cur,
    input  logic                  u_branch,
    input  logic [ADDR_WIDTH-1:0] u_tag,
    input  logic [ADDR_WIDTH-1:0] u_target,
    input  BranchOutcome          u_outcome,
    output BtbEntry               nxt,
    output logic                  we
);

    logic hit;

    assign hit = cur.valid && (cur.tag == u_tag);

    // Train on hit, allocate on taken miss, drop a stale alias on non-branch hit
    always_comb begin
        nxt = cur;
        we  = 1'b0;
        if (u_valid) begin
            if (u_branch) begin
                if (hit) begin
                    we         = 1'b1;
                    nxt.target = u_target;
                    if (u_outcome == TAKEN) begin
                        if (cur.ctr != CTR_STT) nxt.ctr = cur.ctr + 2'd1;
                    end else begin
                        if (cur.ctr != CTR_SNT) nxt.ctr = cur.ctr - 2'd1;
                    end
                end else if (u_outcome == TAKEN) begin
                    we         = 1'b1;
                    nxt.valid  = 1'b1;
                    nxt.tag    = u_tag;
                    nxt.target = u_target;
                    nxt.ctr    = CTR_ALLOC;
                end
            end else if (hit) begin
                we        = 1'b1;
                nxt.valid = 1'b0;
            end
        end
    end

endmodule

// File: rtl/branch_target_predictor.sv
// rtl/branch_target_predictor.sv - direct-mapped BTB with 2-bit counters (BRANCH_PREDICTOR_BYPASS_EN: forward pending update to lookup)
module branch_target_predictor
    import mips_core_pkg::*;
#(
    parameter int INDEX_WIDTH = 6,
    parameter int TAG_WIDTH   = ADDR_WIDTH - INDEX_WIDTH - 2
)
(
    input  logic                  clk,
    input  logic                  rst,
    pc_ifc.in                     i_pc_current,
    branch_prediction_ifc.out     o_prediction,
    branch_decode_ifc.in          i_resolve,
    input  logic                  i_resolve_en,
    input  logic [ADDR_WIDTH-1:0] i_resolve_pc
);

    localparam int ENTRIES = 1 << INDEX_WIDTH;

    BtbEntry table_q [ENTRIES];

    logic                   u_valid;
    logic [INDEX_WIDTH-1:0] u_idx;
    logic [ADDR_WIDTH-1:0]  u_tag;
    logic                   u_branch;
    logic [ADDR_WIDTH-1:0]  u_target;
    BranchOutcome           u_outcome;

    BtbEntry                upd_next;
    logic                   upd_we;

    logic [INDEX_WIDTH-1:0] l_idx;
    logic [ADDR_WIDTH-1:0]  l_tag;
    logic [ADDR_WIDTH-1:0]  l_pc_plus4;
    BtbEntry                l_entry;
    logic                   l_hit;

    logic                   unused_pc_bits;

    assign unused_pc_bits = ^i_resolve_pc[1:0];

    assign l_idx      = i_pc_current.pc[INDEX_WIDTH+1:2];
    assign l_tag      = ADDR_WIDTH'(i_pc_current.pc[INDEX_WIDTH+2 +: TAG_WIDTH]);
    assign l_pc_plus4 = i_pc_current.pc + ADDR_WIDTH'(4);

    // Capture one decode resolution per cycle into the update stage
    always_ff @(posedge clk) begin
        if (rst) begin
            u_valid <= 1'b0;
        end else begin
            u_valid <= i_resolve_en;
            if (i_resolve_en) begin
                u_idx     <= i_resolve_pc[INDEX_WIDTH+1:2];
                u_tag     <= ADDR_WIDTH'(i_resolve_pc[INDEX_WIDTH+2 +: TAG_WIDTH]);
                u_branch  <= i_resolve.valid;
                u_target  <= i_resolve.target;
                u_outcome <= i_resolve.outcome;
            end
        end
    end

    btb_entry_update u_entry_update (
        .u_valid   (u_valid),
        .cur       (table_q[u_idx]),
        .u_branch  (u_branch),
        .u_tag     (u_tag),
        .u_target  (u_target),
        .u_outcome (u_outcome),
        .nxt       (upd_next),
        .we        (upd_we)
    );

    // Table storage: reset clears valid bits and seeds counters, else a single U write
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i].valid <= 1'b0;
                table_q[i].ctr   <= CTR_RESET;
            end
        end else if (upd_we) begin
            table_q[u_idx] <= upd_next;
        end
    end

    // Select the entry seen by lookup, optionally the in-flight post-update value
    always_comb begin
        l_entry = table_q[l_idx];
`ifdef BRANCH_PREDICTOR_BYPASS_EN
        if (u_valid && (u_idx == l_idx)) l_entry = upd_next;
`endif
    end

    assign l_hit = !rst && l_entry.valid && (l_entry.tag == l_tag);

    // Drive prediction outputs; a miss falls through to pc+4
    always_comb begin
        o_prediction.valid           = 1'b0;
        o_prediction.prediction      = NOT_TAKEN;
        o_prediction.target          = l_pc_plus4;
        o_prediction.recovery_target = l_pc_plus4;
        if (l_hit) begin
            o_prediction.valid  = 1'b1;
            o_prediction.target = l_entry.target;
            if (l_entry.ctr[1]) begin
                o_prediction.prediction      = TAKEN;
                o_prediction.recovery_target = l_pc_plus4;
            end else begin
                o_prediction.prediction      = NOT_TAKEN;
                o_prediction.recovery_target = l_entry.target;
            end
        end
    end

endmodule

// File: tb/tb_branch_target_predictor.sv
// tb/tb_branch_target_predictor.sv - directed self-checking bench for branch_target_predictor
module tb_branch_target_predictor;
    import mips_core_pkg::*;

    logic        clk;
    logic        rst;
    logic        i_resolve_en;
    logic [31:0] i_resolve_pc;

    int n_checks = 0;
    int n_fail   = 0;

    pc_ifc                pc_if ();
    branch_prediction_ifc pred_if ();
    branch_decode_ifc     dec_if ();

    branch_target_predictor dut (
        .clk          (clk),
        .rst          (rst),
        .i_pc_current (pc_if),
        .o_prediction (pred_if),
        .i_resolve    (dec_if),
        .i_resolve_en (i_resolve_en),
        .i_resolve_pc (i_resolve_pc)
    );

`ifdef BRANCH_PREDICTOR_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_lookup(input string tag, input logic [31:0] pc, input logic exp_valid,
                                input logic exp_pred, input logic [31:0] exp_target,
                                input logic [31:0] exp_rec);
        pc_if.pc = pc;
        #1;
        check_eq({tag, ".valid"},  32'(pred_if.valid), 32'(exp_valid));
        check_eq({tag, ".pred"},   32'(pred_if.prediction), 32'(exp_pred));
        check_eq({tag, ".target"}, pred_if.target, exp_target);
        check_eq({tag, ".rec"},    pred_if.recovery_target, exp_rec);
    endtask

    task automatic drive(input logic [31:0] pc, input logic br, input logic [31:0] tgt,
                         input BranchOutcome outc);
        i_resolve_en   = 1'b1;
        i_resolve_pc   = pc;
        dec_if.valid   = br;
        dec_if.target  = tgt;
        dec_if.outcome = outc;
        tick();
        i_resolve_en   = 1'b0;
    endtask

    localparam logic [31:0] PA = 32'h0040_0010;
    localparam logic [31:0] PB = 32'h0040_0110;
    localparam logic [31:0] PW = 32'hFFFF_FFFC;
    localparam logic [31:0] TA = 32'h0040_0100;
    localparam logic [31:0] TB = 32'h0040_0200;

    initial begin
        rst            = 1'b1;
        i_resolve_en   = 1'b0;
        i_resolve_pc   = '0;
        dec_if.valid   = 1'b0;
        dec_if.target  = '0;
        dec_if.outcome = NOT_TAKEN;
        pc_if.pc       = PA;
        tick();
        tick();
        check_lookup("in_reset", PA, 1'b0, NOT_TAKEN, 32'h0040_0014, 32'h0040_0014);
        rst = 1'b0;
        check_lookup("post_reset", PA, 1'b0, NOT_TAKEN, 32'h0040_0014, 32'h0040_0014);

        // allocate: visible N+1 with bypass, N+2 without
        drive(PA, 1'b1, TA, TAKEN);
        check_lookup("alloc_n1", PA, BYP, BYP ? TAKEN : NOT_TAKEN,
                     BYP ? TA : 32'h0040_0014, 32'h0040_0014);
        tick();
        check_lookup("alloc_n2", PA, 1'b1, TAKEN, TA, 32'h0040_0014);

        // 10 -> 01 -> 00 back to back
        drive(PA, 1'b1, TA, NOT_TAKEN);
        drive(PA, 1'b1, TA, NOT_TAKEN);
        tick();
        check_lookup("nt_x2", PA, 1'b1, NOT_TAKEN, TA, TA);

        // 00 stays 00, then one TAKEN gives 01: still not taken
        drive(PA, 1'b1, TA, NOT_TAKEN);
        drive(PA, 1'b1, TA, TAKEN);
        tick();
        check_lookup("sat_low", PA, 1'b1, NOT_TAKEN, TA, TA);

        drive(PA, 1'b1, TA, TAKEN);
        tick();
        check_lookup("ctr_wt", PA, 1'b1, TAKEN, TA, 32'h0040_0014);

        // 10 -> 11 -> 11 (no wrap), then NT -> 10 still taken
        drive(PA, 1'b1, TA, TAKEN);
        drive(PA, 1'b1, TA, TAKEN);
        tick();
        check_lookup("sat_high", PA, 1'b1, TAKEN, TA, 32'h0040_0014);
        drive(PA, 1'b1, TA, NOT_TAKEN);
        tick();
        check_lookup("st_to_wt", PA, 1'b1, TAKEN, TA, 32'h0040_0014);
        drive(PA, 1'b1, TA, NOT_TAKEN);
        tick();
        check_lookup("wt_to_wnt", PA, 1'b1, NOT_TAKEN, TA, TA);

        // same index, different tag replaces the entry
        drive(PB, 1'b1, TB, TAKEN);
        tick();
        check_lookup("alias_old", PA, 1'b0, NOT_TAKEN, 32'h0040_0014, 32'h0040_0014);
        check_lookup("alias_new", PB, 1'b1, TAKEN, TB, 32'h0040_0114);

        // non-branch with a different tag leaves the entry alone
        drive(PA, 1'b0, 32'h0, NOT_TAKEN);
        tick();
        check_lookup("nb_other", PB, 1'b1, TAKEN, TB, 32'h0040_0114);

        // non-branch with matching tag invalidates
        drive(PB, 1'b0, 32'h0, NOT_TAKEN);
        tick();
        check_lookup("nb_inval", PB, 1'b0, NOT_TAKEN, 32'h0040_0114, 32'h0040_0114);

        // re-allocate, then reset while a U update is pending
        drive(PB, 1'b1, TB, TAKEN);
        tick();
        check_lookup("realloc", PB, 1'b1, TAKEN, TB, 32'h0040_0114);
        drive(PB, 1'b1, TA, NOT_TAKEN);
        rst            = 1'b1;
        i_resolve_en   = 1'b1;
        i_resolve_pc   = PW;
        dec_if.valid   = 1'b1;
        dec_if.target  = 32'h0000_1000;
        dec_if.outcome = TAKEN;
        check_lookup("rst_force", PB, 1'b0, NOT_TAKEN, 32'h0040_0114, 32'h0040_0114);
        tick();
        rst          = 1'b0;
        i_resolve_en = 1'b0;
        check_lookup("rst_clear", PB, 1'b0, NOT_TAKEN, 32'h0040_0114, 32'h0040_0114);
        tick();
        tick();
        check_lookup("rst_ign_en", PW, 1'b0, NOT_TAKEN, 32'h0, 32'h0);
        check_lookup("rst_nowrite", PB, 1'b0, NOT_TAKEN, 32'h0040_0114, 32'h0040_0114);

        // pc+4 wraps at the top of the address space
        drive(PW, 1'b1, 32'h0000_1000, TAKEN);
        tick();
        check_lookup("wrap_hit", PW, 1'b1, TAKEN, 32'h0000_1000, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
